// File: rtl/sn_buf_arbiter_if.sv
// Snooper-to-buffer bus: snooper write port, ready/ack handshake,
// and steered per-buffer strobes. master = arbiter, slave = environment.
interface sn_buf_arbiter_if #(
  parameter int N_BUFS            = 4,
  parameter int SN_FWD_ADDR_WIDTH = 9,
  parameter int SN_FWD_DATA_WIDTH = 64,
  parameter int SN_INC_WIDTH      = 3
);
  logic [SN_FWD_ADDR_WIDTH-1:0] sn_addr;
  logic [SN_FWD_DATA_WIDTH-1:0] sn_wr_data;
  logic                         sn_wr_en;
  logic [SN_INC_WIDTH-1:0]      sn_byte_inc;
  logic                         sn_done;
  logic                         rdy_for_sn;
  logic                         rdy_for_sn_ack;
  logic [N_BUFS-1:0]            buf_rdy_for_sn;
  logic [N_BUFS-1:0]            buf_rdy_for_sn_ack;
  logic [SN_FWD_ADDR_WIDTH-1:0] buf_addr;
  logic [SN_FWD_DATA_WIDTH-1:0] buf_wr_data;
  logic [SN_INC_WIDTH-1:0]      buf_byte_inc;
  logic [N_BUFS-1:0]            buf_wr_en;
  logic [N_BUFS-1:0]            buf_done;

  modport master (
    input  sn_addr, sn_wr_data, sn_wr_en,
    input  sn_byte_inc, sn_done,
    input  rdy_for_sn_ack, buf_rdy_for_sn,
    output rdy_for_sn, buf_rdy_for_sn_ack,
    output buf_addr, buf_wr_data, buf_byte_inc,
    output buf_wr_en, buf_done
  );

  modport slave (
    output sn_addr, sn_wr_data, sn_wr_en,
    output sn_byte_inc, sn_done,
    output rdy_for_sn_ack, buf_rdy_for_sn,
    input  rdy_for_sn, buf_rdy_for_sn_ack,
    input  buf_addr, buf_wr_data, buf_byte_inc,
    input  buf_wr_en, buf_done
  );
endinterface

// File: rtl/sn_buf_arbiter.sv
// Round-robin arbiter handing one snooper to N_BUFS packet buffers.
// Ports: clk, rst (async, active-low), bus (master), grant_idx, counters.
module sn_buf_arbiter #(
  parameter int N_BUFS            = 4,
  parameter int SEL_WIDTH         = 2,
  parameter int SN_FWD_ADDR_WIDTH = 9,
  parameter int SN_FWD_DATA_WIDTH = 64,
  parameter int SN_INC_WIDTH      = 3,
  parameter int CNT_WIDTH         = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  sn_buf_arbiter_if.master     bus,
  output logic [SEL_WIDTH-1:0] grant_idx,
  output logic [CNT_WIDTH-1:0] pkt_count,
  output logic [CNT_WIDTH-1:0] stray_wr_count
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OFFER = 2'd1;
  localparam logic [1:0] ST_BUSY  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [SEL_WIDTH-1:0] sel_q, sel_d;
  logic [SEL_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_WIDTH-1:0] pkt_count_q, pkt_count_d;
  logic [CNT_WIDTH-1:0] stray_q, stray_d;

  logic                 hit;
  logic [SEL_WIDTH-1:0] hit_idx;
  logic [N_BUFS-1:0]    sel_oh;
  logic                 rdy;
  logic [N_BUFS-1:0]    ack_oh, wr_oh, done_oh;

  // First ready buffer at or after rr_ptr, wrapping at N_BUFS.
  always_comb begin
    int j;
    hit     = 1'b0;
    hit_idx = '0;
    j       = 0;
    for (int i = 0; i < N_BUFS; i++) begin
      j = int'(rr_ptr_q) + i;
      if (j >= N_BUFS) j = j - N_BUFS;
      if (!hit && bus.buf_rdy_for_sn[j]) begin
        hit     = 1'b1;
        hit_idx = SEL_WIDTH'(j);
      end
    end
  end

  always_comb begin
    sel_oh        = '0;
    sel_oh[sel_q] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    rr_ptr_d    = rr_ptr_q;
    pkt_count_d = pkt_count_q;
    stray_d     = stray_q;
    rdy         = 1'b0;
    ack_oh      = '0;
    wr_oh       = '0;
    done_oh     = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (hit) begin
          sel_d   = hit_idx;
          state_d = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (!bus.buf_rdy_for_sn[sel_q]) begin
          state_d = ST_IDLE;
        end else begin
          rdy = 1'b1;
          if (bus.rdy_for_sn_ack) begin
            ack_oh  = sel_oh;
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        wr_oh   = sel_oh & {N_BUFS{bus.sn_wr_en}};
        done_oh = sel_oh & {N_BUFS{bus.sn_done}};
        if (bus.sn_done) begin
          pkt_count_d = pkt_count_q + CNT_WIDTH'(1);
          state_d     = ST_IDLE;
          if (sel_q == SEL_WIDTH'(N_BUFS - 1))
            rr_ptr_d = '0;
          else
            rr_ptr_d = sel_q + SEL_WIDTH'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Snooper activity with no granted buffer is dropped and counted.
    if (state_q != ST_BUSY
        && (bus.sn_wr_en || bus.sn_done)
        && stray_q != '1)
      stray_d = stray_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      rr_ptr_q    <= '0;
      pkt_count_q <= '0;
      stray_q     <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      rr_ptr_q    <= rr_ptr_d;
      pkt_count_q <= pkt_count_d;
      stray_q     <= stray_d;
    end
  end

  assign bus.rdy_for_sn         = rdy;
  assign bus.buf_rdy_for_sn_ack = ack_oh;
  assign bus.buf_wr_en          = wr_oh;
  assign bus.buf_done           = done_oh;
  assign bus.buf_addr           = bus.sn_addr;
  assign bus.buf_wr_data        = bus.sn_wr_data;
  assign bus.buf_byte_inc       = bus.sn_byte_inc;
  assign grant_idx              = sel_q;
  assign pkt_count              = pkt_count_q;
  assign stray_wr_count         = stray_q;

endmodule

// File: tb/tb_sn_buf_arbiter.sv
// Directed bench for sn_buf_arbiter: a 4-buffer and a 3-buffer instance,
// write/grant scoreboards, immediate-assertion checks.
module tb_sn_buf_arbiter;
  logic clk;
  logic rst;

  sn_buf_arbiter_if #(.N_BUFS(4)) ifa ();
  sn_buf_arbiter_if #(.N_BUFS(3)) ifb ();

  logic [1:0]  gi_a, gi_b;
  logic [15:0] pkt_a, pkt_b, str_a, str_b;

  sn_buf_arbiter #(.N_BUFS(4)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa),
    .grant_idx(gi_a), .pkt_count(pkt_a),
    .stray_wr_count(str_a)
  );

  sn_buf_arbiter #(.N_BUFS(3)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb),
    .grant_idx(gi_b), .pkt_count(pkt_b),
    .stray_wr_count(str_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [72:0] wq[$];
  logic [1:0]  gq[$];

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drive one write into A and record what the granted buffer must see.
  task automatic a_write(input logic [8:0] addr);
    logic [63:0] d;
    d = {$urandom, $urandom};
    ifa.sn_wr_en   = 1'b1;
    ifa.sn_addr    = addr;
    ifa.sn_wr_data = d;
    wq.push_back({addr, d});
  endtask

  // Compare a forwarded write against the scoreboard head.
  task automatic a_pop_write(input logic [3:0] exp_oh);
    logic [72:0] e;
    chk("wr_oh", 64'(ifa.buf_wr_en), 64'(exp_oh));
    if (wq.size() == 0) begin
      chk("wq_underflow", 64'(wq.size()), 64'd1);
    end else begin
      e = wq.pop_front();
      chk("wr_addr", 64'(ifa.buf_addr), 64'(e[72:64]));
      chk("wr_data", ifa.buf_wr_data, e[63:0]);
    end
  endtask

  // From OFFER: accept, then end the packet with a bare sn_done.
  task automatic a_finish(input logic [3:0] exp_oh);
    ifa.rdy_for_sn_ack = 1'b1;
    #1;
    chk("fin_ack", 64'(ifa.buf_rdy_for_sn_ack), 64'(exp_oh));
    cyc();
    ifa.rdy_for_sn_ack = 1'b0;
    ifa.buf_rdy_for_sn = '0;
    ifa.sn_done        = 1'b1;
    #1;
    chk("fin_done", 64'(ifa.buf_done), 64'(exp_oh));
    cyc();
    ifa.sn_done = 1'b0;
  endtask

  initial begin
    int wr_cycles;
    int n;
    logic [1:0] eg;
    logic [2:0] ohb;

    rst = 1'b0;
    ifa.sn_addr = '0; ifa.sn_wr_data = '0;
    ifa.sn_wr_en = 1'b0; ifa.sn_byte_inc = '0;
    ifa.sn_done = 1'b0; ifa.rdy_for_sn_ack = 1'b0;
    ifa.buf_rdy_for_sn = '0;
    ifb.sn_addr = '0; ifb.sn_wr_data = '0;
    ifb.sn_wr_en = 1'b0; ifb.sn_byte_inc = '0;
    ifb.sn_done = 1'b0; ifb.rdy_for_sn_ack = 1'b0;
    ifb.buf_rdy_for_sn = '0;
    cyc(); cyc();
    chk("rst_rdy", 64'(ifa.rdy_for_sn), 64'd0);
    chk("rst_grant", 64'(gi_a), 64'd0);
    chk("rst_pkt", 64'(pkt_a), 64'd0);
    chk("rst_stray", 64'(str_a), 64'd0);
    rst = 1'b1;
    cyc();

    // Ready on buffer 2 offered one cycle later.
    ifa.buf_rdy_for_sn = 4'b0100;
    #1;
    chk("idle_rdy", 64'(ifa.rdy_for_sn), 64'd0);
    cyc();
    chk("offer_rdy", 64'(ifa.rdy_for_sn), 64'd1);
    chk("offer_grant", 64'(gi_a), 64'd2);
    ifa.rdy_for_sn_ack = 1'b1;
    #1;
    chk("ack_oh", 64'(ifa.buf_rdy_for_sn_ack), 64'h4);
    cyc();
    ifa.rdy_for_sn_ack = 1'b0;
    ifa.buf_rdy_for_sn = '0;
    #1;
    chk("ack_once", 64'(ifa.buf_rdy_for_sn_ack), 64'd0);
    chk("busy_rdy", 64'(ifa.rdy_for_sn), 64'd0);

    // Three words, then done.
    wr_cycles = 0;
    for (int i = 0; i < 3; i++) begin
      a_write(9'(i));
      #1;
      if (ifa.buf_wr_en != 0) wr_cycles++;
      a_pop_write(4'b0100);
      cyc();
    end
    ifa.sn_wr_en = 1'b0;
    ifa.sn_done  = 1'b1;
    #1;
    if (ifa.buf_wr_en != 0) wr_cycles++;
    chk("done_oh", 64'(ifa.buf_done), 64'h4);
    cyc();
    ifa.sn_done = 1'b0;
    #1;
    chk("wr_cycles", 64'(wr_cycles), 64'd3);
    chk("wq_empty", 64'(wq.size()), 64'd0);
    chk("pkt_1", 64'(pkt_a), 64'd1);

    // Search resumes at index 3: 3 wins over 0.
    ifa.buf_rdy_for_sn = 4'b1001;
    cyc();
    chk("next_grant", 64'(gi_a), 64'd3);
    a_finish(4'b1000);

    // Offer to buffer 1 withdrawn before ack.
    ifa.buf_rdy_for_sn = 4'b0010;
    cyc();
    chk("drop_grant", 64'(gi_a), 64'd1);
    chk("drop_rdy_pre", 64'(ifa.rdy_for_sn), 64'd1);
    ifa.buf_rdy_for_sn = 4'b0000;
    #1;
    chk("drop_rdy", 64'(ifa.rdy_for_sn), 64'd0);
    cyc();
    ifa.rdy_for_sn_ack = 1'b1;
    #1;
    chk("late_ack", 64'(ifa.buf_rdy_for_sn_ack), 64'd0);
    cyc();
    ifa.rdy_for_sn_ack = 1'b0;
    ifa.buf_rdy_for_sn = 4'b1010;
    cyc();
    chk("reoffer", 64'(gi_a), 64'd1);
    a_finish(4'b0010);
    chk("pkt_3", 64'(pkt_a), 64'd3);

    // Stray writes while idle.
    ifa.sn_wr_en = 1'b1;
    #1;
    chk("stray_fwd0", 64'(ifa.buf_wr_en), 64'd0);
    cyc();
    chk("stray_fwd1", 64'(ifa.buf_wr_en), 64'd0);
    cyc();
    ifa.sn_wr_en = 1'b0;
    chk("stray_cnt", 64'(str_a), 64'd2);

    // Reset in the middle of a packet to buffer 2.
    ifa.buf_rdy_for_sn = 4'b1111;
    cyc();
    chk("rst_pre_grant", 64'(gi_a), 64'd2);
    ifa.rdy_for_sn_ack = 1'b1;
    cyc();
    ifa.rdy_for_sn_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a_write(9'(i + 8));
      #1;
      a_pop_write(4'b0100);
      cyc();
    end
    ifa.sn_addr  = 9'd10;
    ifa.sn_wr_en = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_wr", 64'(ifa.buf_wr_en), 64'd0);
    chk("mid_rst_rdy", 64'(ifa.rdy_for_sn), 64'd0);
    chk("mid_rst_grant", 64'(gi_a), 64'd0);
    chk("mid_rst_pkt", 64'(pkt_a), 64'd0);
    chk("mid_rst_stray", 64'(str_a), 64'd0);
    ifa.sn_done = 1'b1;
    #1;
    chk("mid_rst_done", 64'(ifa.buf_done), 64'd0);
    cyc();
    ifa.sn_wr_en = 1'b0;
    ifa.sn_done  = 1'b0;
    rst = 1'b1;
    cyc();
    chk("post_rst_grant", 64'(gi_a), 64'd0);
    chk("post_rst_rdy", 64'(ifa.rdy_for_sn), 64'd1);
    ifa.buf_rdy_for_sn = '0;
    cyc();

    // N_BUFS=3 round robin, six back-to-back packets.
    for (int p = 0; p < 6; p++) gq.push_back(2'(p % 3));
    ifb.buf_rdy_for_sn = 3'b111;
    for (int p = 0; p < 6; p++) begin
      n = 0;
      while (!ifb.rdy_for_sn && n < 8) begin
        cyc();
        n++;
      end
      chk("rr_offer", 64'(ifb.rdy_for_sn), 64'd1);
      eg = gq.pop_front();
      chk("rr_grant", 64'(gi_b), 64'(eg));
      ifb.rdy_for_sn_ack = 1'b1;
      cyc();
      ifb.rdy_for_sn_ack = 1'b0;
      ifb.sn_wr_en = 1'b1;
      ifb.sn_done  = 1'b1;
      ohb = 3'b001 << eg;
      #1;
      chk("rr_wr", 64'(ifb.buf_wr_en), 64'(ohb));
      chk("rr_done", 64'(ifb.buf_done), 64'(ohb));
      cyc();
      ifb.sn_wr_en = 1'b0;
      ifb.sn_done  = 1'b0;
    end
    chk("rr_pkt", 64'(pkt_b), 64'd6);
    chk("rr_stray", 64'(str_b), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sn_buf_arbiter.md
Name: sn_buf_arbiter

Overview:
- Sits between one axistream_snooper and N_BUFS packet-memory buffers (one per packet filter).
- Owns the snooper's rdy_for_sn/rdy_for_sn_ack handshake and picks the next ready buffer round-robin.
- Steers the snooper write port (addr/data/wr_en/byte_inc/done) to the granted buffer until sn_done, then rotates.

Parameters:
N_BUFS, 4, number of downstream packet buffers (2..16, need not be a power of 2)
SEL_WIDTH, 2, width of the buffer index; must be >= clog2(N_BUFS)
SN_FWD_ADDR_WIDTH, 9, buffer word-address width
SN_FWD_DATA_WIDTH, 64, write data width
SN_INC_WIDTH, 3, byte-increment width
CNT_WIDTH, 16, width of the statistics counters

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  asynchronous reset, active-low (0 = reset)
sn_addr  in  SN_FWD_ADDR_WIDTH  snooper write address
sn_wr_data  in  SN_FWD_DATA_WIDTH  snooper write data
sn_wr_en  in  1  snooper write strobe
sn_byte_inc  in  SN_INC_WIDTH  snooper byte increment
sn_done  in  1  snooper end-of-packet pulse
rdy_for_sn  out  1  a buffer is offered to the snooper
rdy_for_sn_ack  in  1  snooper accepts the offered buffer
buf_rdy_for_sn  in  N_BUFS  per-buffer ready-for-snooper
buf_rdy_for_sn_ack  out  N_BUFS  one-hot accept pulse to the granted buffer
buf_addr  out  SN_FWD_ADDR_WIDTH  shared address bus (sn_addr passthrough)
buf_wr_data  out  SN_FWD_DATA_WIDTH  shared data bus (sn_wr_data passthrough)
buf_byte_inc  out  SN_INC_WIDTH  shared byte-increment bus
buf_wr_en  out  N_BUFS  one-hot write strobe
buf_done  out  N_BUFS  one-hot done pulse
grant_idx  out  SEL_WIDTH  index of the offered or granted buffer
pkt_count  out  CNT_WIDTH  packets completed (wraps)
stray_wr_count  out  CNT_WIDTH  sn_wr_en or sn_done seen outside BUSY (saturates at all-ones)

Behaviour:
- States: IDLE, OFFER, BUSY. The reset state is IDLE.
- Registers cleared by reset: sel=0, rr_ptr=0, pkt_count=0, stray_wr_count=0.
- While rst=0, all strobe outputs are 0.
- IDLE:
  - Search buf_rdy_for_sn starting at rr_ptr, wrapping modulo N_BUFS (not modulo 2^SEL_WIDTH).
  - On a hit, register sel=index and go to OFFER next cycle. If there is no hit, stay in IDLE.
  - Latency: a buffer raising ready in cycle t gives rdy_for_sn=1 in cycle t+1.
- OFFER:
  - rdy_for_sn = buf_rdy_for_sn[sel], combinational.
  - If buf_rdy_for_sn[sel] drops before the ack, go back to IDLE next cycle and keep rr_ptr unchanged.
  - If rdy_for_sn & rdy_for_sn_ack in the same cycle: buf_rdy_for_sn_ack[sel]=1 for exactly that cycle (combinational), then go to BUSY.
  - An ack while rdy_for_sn=0 is ignored.
- BUSY:
  - rdy_for_sn=0.
  - buf_wr_en[sel]=sn_wr_en and buf_done[sel]=sn_done, combinational with zero latency; all other bits are 0.
  - buf_addr, buf_wr_data and buf_byte_inc always pass the sn_* inputs straight through (shared buses, ungated).
  - On sn_done: pkt_count+1, rr_ptr=(sel+1) mod N_BUFS, go to IDLE next cycle.
  - A write and sn_done in the same cycle are both forwarded.
- Stray events: sn_wr_en=1 or sn_done=1 in IDLE or OFFER is not forwarded and increments stray_wr_count by 1 per cycle, saturating.
- Buffer ready changes during BUSY:
  - Changes on other buffers are ignored.
  - buf_rdy_for_sn[sel] falling during BUSY does not abort the grant.
- grant_idx = sel at all times.
- Asynchronous reset mid-BUSY: the packet is abandoned, no buf_done is issued, and the counters clear.

Test Plan:
- Reset, then buf_rdy_for_sn=4'b0100 in cycle 3 -> rdy_for_sn=1 in cycle 4, grant_idx=2; ack -> buf_rdy_for_sn_ack=4'b0100 for one cycle.
- After the grant to 2: write 3 words at addr 0..2, then sn_done -> buf_wr_en=4'b0100 on exactly those 3 cycles, buf_done=4'b0100 once, pkt_count=1, and the next grant searches from index 3.
- All buffers ready, N_BUFS=3, 6 back-to-back packets -> grant order 0,1,2,0,1,2 (wrap at 3, never index 3); pkt_count=6.
- OFFER to buffer 1, then buf_rdy_for_sn[1] drops before the ack -> rdy_for_sn falls the same cycle, the arbiter returns to IDLE, a late ack produces no buf_rdy_for_sn_ack, and the next offer is again buffer 1 if it re-raises ready.
- sn_wr_en pulsed 2 cycles while IDLE -> buf_wr_en stays 0, stray_wr_count=2.
- Assert rst=0 mid-packet (2 of 4 words written) -> all outputs 0 asynchronously, no buf_done, counters 0, and after release the next grant starts at buffer 0.
